// File: rtl/pilha_pkg.sv
// Shared definitions for the parametrised operand stack.
// Holds the op-code width and the op-code constants. The UC decoder and the
// benches import the same constants.
package pilha_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP      = 3'b000;
   localparam logic [OP_W-1:0] OP_PUSH     = 3'b001;
   localparam logic [OP_W-1:0] OP_POP      = 3'b010;
   localparam logic [OP_W-1:0] OP_DUP      = 3'b011;
   localparam logic [OP_W-1:0] OP_SWAP     = 3'b100;
   localparam logic [OP_W-1:0] OP_REPL     = 3'b101;
   localparam logic [OP_W-1:0] OP_POP2PUSH = 3'b110;
   localparam logic [OP_W-1:0] OP_CLEAR    = 3'b111;

endpackage

// File: rtl/pilha_mem.sv
// DEPTH x DATA_W register file that backs the stack.
// Ports:
//   clk              write clock, rising edge
//   rd0/rd1 addr/data asynchronous read ports, used for TOS and NOS
//   we0/wa0/wd0      synchronous write port 0
//   we1/wa1/wd1      synchronous write port 1; SWAP uses both ports together
// The storage has no reset because its contents do not matter while count is 0.
module pilha_mem #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic [AW-1:0]     rd0_addr_i,
   output logic [DATA_W-1:0] rd0_data_o,
   input  logic [AW-1:0]     rd1_addr_i,
   output logic [DATA_W-1:0] rd1_data_o,
   input  logic              we0_i,
   input  logic [AW-1:0]     wa0_i,
   input  logic [DATA_W-1:0] wd0_i,
   input  logic              we1_i,
   input  logic [AW-1:0]     wa1_i,
   input  logic [DATA_W-1:0] wd1_i
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // The top level never writes the same address on both ports in one cycle.
   always_ff @(posedge clk) begin
      if (we0_i) mem_q[wa0_i] <= wd0_i;
      if (we1_i) mem_q[wa1_i] <= wd1_i;
   end

   assign rd0_data_o = mem_q[rd0_addr_i];
   assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/pilha_parametrizada.sv
// Parametrised LIFO operand stack for the stack-machine datapath.
// Executes one op per clock: NOP, PUSH, POP, DUP, SWAP, REPL, POP2PUSH and CLEAR.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   op               stack operation, sampled at the rising edge
//   src_sel          selects the write data: 0 = din_uc, 1 = low DATA_W bits of din_ula
//   din_uc, din_ula  write data from the control unit and from the ALU
//   tos, nos         top and next-on-stack; 0 when those entries are absent
//   dout             registered value removed by the last POP or POP2PUSH
//   count            occupancy; empty and full are decoded from count
//   ovf, unf         sticky rejection flags; cleared by CLEAR or rst
module pilha_parametrizada
   import pilha_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ULA_W  = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   op,
   input  logic              src_sel,
   input  logic [DATA_W-1:0] din_uc,
   input  logic [ULA_W-1:0]  din_ula,
   output logic [DATA_W-1:0] tos,
   output logic [DATA_W-1:0] nos,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic [DATA_W-1:0] wr_data;
   logic [AW-1:0]     tos_addr, nos_addr;
   logic [DATA_W-1:0] tos_raw, nos_raw;
   logic              has1, has2, is_full;
   logic              we0, we1;
   logic [AW-1:0]     wa0, wa1;
   logic [DATA_W-1:0] wd0, wd1;

   // Only the low DATA_W bits of the ALU result are stored.
   assign wr_data = src_sel ? din_ula[DATA_W-1:0] : din_uc;

   generate
      if (ULA_W > DATA_W) begin : g_ula_hi
         logic unused_ula_hi;
         assign unused_ula_hi = ^din_ula[ULA_W-1:DATA_W];
      end
   endgenerate

   assign has1    = (count_q != '0);
   assign has2    = (count_q >= CNT_W'(2));
   assign is_full = (count_q == CNT_W'(DEPTH));

   // Read addresses are pinned to 0 when the entry is absent so they stay in range.
   assign tos_addr = has1 ? AW'(count_q - CNT_W'(1)) : '0;
   assign nos_addr = has2 ? AW'(count_q - CNT_W'(2)) : '0;

   pilha_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk        (clk),
      .rd0_addr_i (tos_addr),
      .rd0_data_o (tos_raw),
      .rd1_addr_i (nos_addr),
      .rd1_data_o (nos_raw),
      .we0_i      (we0),
      .wa0_i      (wa0),
      .wd0_i      (wd0),
      .we1_i      (we1),
      .wa1_i      (wa1),
      .wd1_i      (wd1)
   );

   // Op decode: rejected ops only touch the sticky flags.
   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we0     = 1'b0;
      wa0     = tos_addr;
      wd0     = wr_data;
      we1     = 1'b0;
      wa1     = nos_addr;
      wd1     = tos_raw;

      case (op)
         OP_PUSH: begin
            if (!is_full) begin
               we0     = 1'b1;
               wa0     = AW'(count_q);
               count_d = count_q + CNT_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end
         OP_POP: begin
            if (has1) begin
               dout_d  = tos_raw;
               count_d = count_q - CNT_W'(1);
            end else begin
               unf_d = 1'b1;
            end
         end
         OP_DUP: begin
            if (!has1) begin
               unf_d = 1'b1;
            end else if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               we0     = 1'b1;
               wa0     = AW'(count_q);
               wd0     = tos_raw;
               count_d = count_q + CNT_W'(1);
            end
         end
         OP_SWAP: begin
            if (has2) begin
               we0 = 1'b1;
               wd0 = nos_raw;
               we1 = 1'b1;
            end else begin
               unf_d = 1'b1;
            end
         end
         OP_REPL: begin
            if (has1) begin
               we0 = 1'b1;
            end else begin
               unf_d = 1'b1;
            end
         end
         OP_POP2PUSH: begin
            // The result overwrites the NOS slot, and the old TOS slot is dropped.
            if (has2) begin
               dout_d  = tos_raw;
               we1     = 1'b1;
               wd1     = wr_data;
               count_d = count_q - CNT_W'(1);
            end else begin
               unf_d = 1'b1;
            end
         end
         OP_CLEAR: begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
         end
         default: ;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign tos   = has1 ? tos_raw : '0;
   assign nos   = has2 ? nos_raw : '0;
   assign dout  = dout_q;
   assign count = count_q;
   assign empty = !has1;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_pilha_parametrizada.sv
module tb_pilha_parametrizada;
   import pilha_pkg::*;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ULA_W  = 32;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [OP_W-1:0]   op = OP_NOP;
   logic              src_sel = 1'b0;
   logic [DATA_W-1:0] din_uc = '0;
   logic [ULA_W-1:0]  din_ula = '0;
   logic [DATA_W-1:0] tos, nos, dout;
   logic [CNT_W-1:0]  count;
   logic              empty, full, ovf, unf;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model and dout scoreboard.
   logic [DATA_W-1:0] stk[$];
   logic [DATA_W-1:0] sb[$];
   logic [DATA_W-1:0] m_dout = '0;
   logic              m_ovf = 1'b0;
   logic              m_unf = 1'b0;
   logic [DATA_W-1:0] exp_v;

   always #5 clk = ~clk;

   pilha_parametrizada #(
      .DATA_W (DATA_W),
      .ULA_W  (ULA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .src_sel (src_sel),
      .din_uc  (din_uc),
      .din_ula (din_ula),
      .tos     (tos),
      .nos     (nos),
      .dout    (dout),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .ovf     (ovf),
      .unf     (unf)
   );

   function automatic logic [DATA_W-1:0] m_tos();
      return (stk.size() > 0) ? stk[stk.size()-1] : '0;
   endfunction

   function automatic logic [DATA_W-1:0] m_nos();
      return (stk.size() > 1) ? stk[stk.size()-2] : '0;
   endfunction

   function automatic void model_reset();
      stk.delete();
      sb.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endfunction

   // Drive one op for one edge, then update the model; expected dout goes to the scoreboard.
   task automatic do_op(input logic [OP_W-1:0] o, input logic sel,
                        input logic [DATA_W-1:0] uc, input logic [ULA_W-1:0] ula);
      logic [DATA_W-1:0] d, t;
      int n;
      @(negedge clk);
      op = o; src_sel = sel; din_uc = uc; din_ula = ula;
      @(posedge clk);
      #1;
      op = OP_NOP;
      d = sel ? ula[DATA_W-1:0] : uc;
      n = stk.size();
      case (o)
         OP_PUSH: if (n < DEPTH) stk.push_back(d); else m_ovf = 1'b1;
         OP_POP: if (n >= 1) begin m_dout = stk.pop_back(); sb.push_back(m_dout); end
                 else m_unf = 1'b1;
         OP_DUP: if (n == 0) m_unf = 1'b1;
                 else if (n == DEPTH) m_ovf = 1'b1;
                 else stk.push_back(stk[n-1]);
         OP_SWAP: if (n >= 2) begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
                  else m_unf = 1'b1;
         OP_REPL: if (n >= 1) stk[n-1] = d; else m_unf = 1'b1;
         OP_POP2PUSH: if (n >= 2) begin
                         m_dout = stk.pop_back(); sb.push_back(m_dout);
                         void'(stk.pop_back()); stk.push_back(d);
                      end else m_unf = 1'b1;
         OP_CLEAR: begin stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
         default: ;
      endcase
   endtask

   task automatic test_reset();
      rst = 1'b1; op = OP_PUSH; din_uc = 16'h00AA; src_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", empty); end
      tests_run++; if (tos !== '0) begin tests_failed++; $display("FAIL reset_tos got %h want 0", tos); end
      tests_run++; if (dout !== '0) begin tests_failed++; $display("FAIL reset_dout got %h want 0", dout); end
      tests_run++; if ({ovf, unf} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got %b%b want 00", ovf, unf); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      op = OP_NOP;
      stk.push_back(16'h00AA);
      tests_run++; if (count !== CNT_W'(1)) begin tests_failed++; $display("FAIL release_count got %0d want 1", count); end
      tests_run++; if (tos !== 16'h00AA) begin tests_failed++; $display("FAIL release_tos got %h want 00aa", tos); end
      do_op(OP_CLEAR, 1'b0, '0, '0);
   endtask

   task automatic test_push_pop();
      do_op(OP_PUSH, 1'b0, 16'd3, 32'hDEAD_BEEF);
      do_op(OP_PUSH, 1'b1, 16'hFFFF, 32'h0001_0002);
      tests_run++; if (tos !== 16'h0002) begin tests_failed++; $display("FAIL pp_tos got %h want 0002", tos); end
      tests_run++; if (nos !== 16'd3) begin tests_failed++; $display("FAIL pp_nos got %h want 0003", nos); end
      tests_run++; if (count !== CNT_W'(2)) begin tests_failed++; $display("FAIL pp_count got %0d want 2", count); end
      do_op(OP_POP, 1'b0, '0, '0);
      exp_v = sb.pop_front();
      tests_run++; if (dout !== exp_v || exp_v !== 16'd2) begin tests_failed++; $display("FAIL pp_pop1_dout got %h want %h", dout, exp_v); end
      tests_run++; if (tos !== 16'd3) begin tests_failed++; $display("FAIL pp_pop1_tos got %h want 0003", tos); end
      do_op(OP_POP, 1'b0, '0, '0);
      exp_v = sb.pop_front();
      tests_run++; if (dout !== exp_v || exp_v !== 16'd3) begin tests_failed++; $display("FAIL pp_pop2_dout got %h want %h", dout, exp_v); end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL pp_empty got %b want 1", empty); end
   endtask

   task automatic test_full();
      for (int i = 1; i <= int'(DEPTH); i++) do_op(OP_PUSH, 1'b0, DATA_W'(i), '0);
      tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL full_flag got %b want 1", full); end
      tests_run++; if (tos !== DATA_W'(DEPTH)) begin tests_failed++; $display("FAIL full_tos got %0d want %0d", tos, DEPTH); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL full_ovf_early got %b want 0", ovf); end
      do_op(OP_PUSH, 1'b0, 16'd99, '0);
      tests_run++; if (tos !== DATA_W'(DEPTH)) begin tests_failed++; $display("FAIL ovf_tos got %0d want %0d", tos, DEPTH); end
      tests_run++; if (count !== CNT_W'(DEPTH)) begin tests_failed++; $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", ovf); end
      do_op(OP_DUP, 1'b0, '0, '0);
      tests_run++; if (ovf !== 1'b1 || count !== CNT_W'(DEPTH)) begin tests_failed++; $display("FAIL dup_full got ovf=%b count=%0d want 1/%0d", ovf, count, DEPTH); end
      tests_run++; if (nos !== DATA_W'(DEPTH-1)) begin tests_failed++; $display("FAIL full_nos got %0d want %0d", nos, DEPTH-1); end
      do_op(OP_CLEAR, 1'b0, '0, '0);
      tests_run++; if (count !== '0 || ovf !== 1'b0) begin tests_failed++; $display("FAIL clear_full got count=%0d ovf=%b want 0/0", count, ovf); end
   endtask

   task automatic test_ops();
      do_op(OP_PUSH, 1'b0, 16'd5, '0);
      do_op(OP_PUSH, 1'b0, 16'd7, '0);
      do_op(OP_SWAP, 1'b0, '0, '0);
      tests_run++; if (tos !== 16'd5 || nos !== 16'd7) begin tests_failed++; $display("FAIL swap got tos=%0d nos=%0d want 5/7", tos, nos); end
      do_op(OP_DUP, 1'b0, '0, '0);
      tests_run++; if (count !== CNT_W'(3) || tos !== 16'd5) begin tests_failed++; $display("FAIL dup got count=%0d tos=%0d want 3/5", count, tos); end
      do_op(OP_REPL, 1'b0, 16'd9, '0);
      tests_run++; if (tos !== 16'd9 || count !== CNT_W'(3)) begin tests_failed++; $display("FAIL repl got tos=%0d count=%0d want 9/3", tos, count); end
      tests_run++; if (nos !== 16'd5) begin tests_failed++; $display("FAIL repl_nos got %0d want 5", nos); end
      do_op(OP_POP2PUSH, 1'b1, '0, 32'hABCD_000C);
      exp_v = sb.pop_front();
      tests_run++; if (dout !== exp_v || exp_v !== 16'd9) begin tests_failed++; $display("FAIL p2p_dout got %0d want %0d", dout, exp_v); end
      tests_run++; if (tos !== 16'd12 || nos !== 16'd7 || count !== CNT_W'(2)) begin
         tests_failed++; $display("FAIL p2p_state got tos=%0d nos=%0d count=%0d want 12/7/2", tos, nos, count); end
      do_op(OP_CLEAR, 1'b0, '0, '0);
   endtask

   task automatic test_underflow();
      do_op(OP_POP, 1'b0, '0, '0);
      tests_run++; if (unf !== 1'b1 || count !== '0 || dout !== 16'd9) begin
         tests_failed++; $display("FAIL unf_pop got unf=%b count=%0d dout=%0d want 1/0/9", unf, count, dout); end
      do_op(OP_SWAP, 1'b0, '0, '0);
      do_op(OP_REPL, 1'b0, 16'h1234, '0);
      tests_run++; if (unf !== 1'b1 || count !== '0 || dout !== 16'd9 || tos !== '0) begin
         tests_failed++; $display("FAIL unf_swap_repl got unf=%b count=%0d dout=%0d tos=%h want 1/0/9/0", unf, count, dout, tos); end
      do_op(OP_PUSH, 1'b0, 16'h0042, '0);
      do_op(OP_SWAP, 1'b0, '0, '0);
      do_op(OP_POP2PUSH, 1'b0, 16'h0055, '0);
      tests_run++; if (tos !== 16'h0042 || nos !== '0 || count !== CNT_W'(1) || dout !== 16'd9) begin
         tests_failed++; $display("FAIL unf_one got tos=%h nos=%h count=%0d dout=%0d want 0042/0/1/9", tos, nos, count, dout); end
      do_op(OP_CLEAR, 1'b0, '0, '0);
      tests_run++; if (unf !== 1'b0 || ovf !== 1'b0 || dout !== 16'd9) begin
         tests_failed++; $display("FAIL unf_clear got unf=%b ovf=%b dout=%0d want 0/0/9", unf, ovf, dout); end
   endtask

   task automatic test_back_to_back();
      int r;
      logic [OP_W-1:0] o;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         if (r <= 5) o = OP_PUSH;
         else if (r <= 8) o = OP_POP;
         else if (r == 9) o = OP_DUP;
         else if (r == 10) o = OP_SWAP;
         else if (r == 11) o = OP_REPL;
         else if (r == 12) o = OP_POP2PUSH;
         else if (r == 13) o = OP_NOP;
         else if (r == 15 && $urandom_range(0, 3) == 0) o = OP_CLEAR;
         else o = OP_POP;
         do_op(o, 1'($urandom_range(0, 1)), DATA_W'($urandom), ULA_W'($urandom));
         while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            tests_run++; if (dout !== exp_v) begin tests_failed++; $display("FAIL b2b_dout step %0d got %h want %h", i, dout, exp_v); end
         end
         tests_run++;
         if (tos !== m_tos() || nos !== m_nos() || count !== CNT_W'(stk.size()) ||
             ovf !== m_ovf || unf !== m_unf || empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH)) begin
            tests_failed++;
            $display("FAIL b2b_state step %0d op %0d got tos=%h nos=%h count=%0d ovf=%b unf=%b want tos=%h nos=%h count=%0d ovf=%b unf=%b",
                     i, o, tos, nos, count, ovf, unf, m_tos(), m_nos(), stk.size(), m_ovf, m_unf);
         end
      end
      do_op(OP_CLEAR, 1'b0, '0, '0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i <= int'(DEPTH); i++) do_op(OP_PUSH, 1'b0, DATA_W'(100 + i), '0);
      for (int i = 0; i < int'(DEPTH) - 4; i++) do_op(OP_POP, 1'b0, '0, '0);
      sb.delete();
      tests_run++; if (count !== CNT_W'(4) || ovf !== 1'b1) begin
         tests_failed++; $display("FAIL pre_rst got count=%0d ovf=%b want 4/1", count, ovf); end
      @(posedge clk);
      #3;
      op = OP_PUSH;
      rst = 1'b1;
      #1;
      tests_run++; if (count !== '0 || ovf !== 1'b0 || unf !== 1'b0 || tos !== '0 || nos !== '0 || dout !== '0 || empty !== 1'b1) begin
         tests_failed++; $display("FAIL async_rst got count=%0d ovf=%b unf=%b tos=%h nos=%h dout=%h want all 0", count, ovf, unf, tos, nos, dout); end
      @(negedge clk);
      op = OP_NOP;
      rst = 1'b0;
      model_reset();
      do_op(OP_PUSH, 1'b0, 16'h0777, '0);
      tests_run++; if (count !== CNT_W'(1) || tos !== 16'h0777) begin
         tests_failed++; $display("FAIL post_rst got count=%0d tos=%h want 1/0777", count, tos); end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_full();
      test_ops();
      test_underflow();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
